rec_assembler: RTL

REC_ASSEMBLER -- requirements
Module: rec_assembler

---
 rtl/rec_assembler_pkg.sv | 21 ++
 rtl/rec_assembler_lane_wr.sv | 25 ++
 rtl/rec_assembler.sv | 112 +++++++++++
 3 files changed

// File: rtl/rec_assembler_pkg.sv
// Shared types and constants for the byte-serial record assembler.
package rec_assembler_pkg;

    localparam int REC_NBYTES = 8;
    localparam int REC_BBITS  = 16;
    localparam int REC_L      = REC_NBYTES + REC_BBITS / 8;
    localparam int REC_W      = 8 * REC_NBYTES + REC_BBITS;
    localparam int LEN_W      = $clog2(REC_L + 1);

    // Field a occupies the MSBs; a[REC_NBYTES-1] holds the first byte received.
    typedef struct packed {
        logic [REC_NBYTES-1:0][7:0] a;
        logic [REC_BBITS-1:0]       b;
    } rec_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/rec_assembler_lane_wr.sv
// Lane write decode: drops one byte into the lane selected by the byte count.
module rec_lane_wr
    import rec_assembler_pkg::*;
(
    input  rec_t             rec_i,
    input  logic [LEN_W-1:0] cnt_i,
    input  logic [7:0]       byte_i,
    output rec_t             rec_o
);

    logic [REC_W-1:0] flat;

    // Arrival order k maps onto the flat vector from the top down, which walks
    // through a (MSB lane first) and then through b (MSB lane first).
    always_comb begin
        flat = rec_i;
        for (int k = 0; k < REC_L; k++) begin
            if (int'(cnt_i) == k) begin
                flat[REC_W-1-8*k -: 8] = byte_i;
            end
        end
        rec_o = flat;
    end

endmodule

// File: rtl/rec_assembler.sv
// Byte-serial record assembler: packs MSB-first bytes into a fixed-length
// record, closing early on in_last, and hands records to a one-deep output slot.
//
// state | meaning
// FILL  | accepting bytes into the assembly register
// HOLD  | record complete, waiting for the output slot to free up
module rec_assembler
    import rec_assembler_pkg::*;
#(
    parameter int NBYTES = REC_NBYTES,
    parameter int BBITS  = REC_BBITS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [7:0]                            in_data,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [8*NBYTES+BBITS-1:0]             out_rec,
    output logic [$clog2(NBYTES+BBITS/8+1)-1:0]   out_len,
    output logic                                  out_short
);

    localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'(REC_L - 1);

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    rec_t             asm_q;
    rec_t             asm_d;
    logic             short_q;
    rec_t             out_rec_q;
    logic [LEN_W-1:0] out_len_q;
    logic             out_short_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic in_xfer;
    logic last_byte;
    logic load;

    assign in_xfer   = in_valid && in_ready_q;
    assign last_byte = in_last || (cnt_q == CNT_LAST);
    assign load      = (state_q == ST_HOLD) && (!out_valid_q || out_ready);

    rec_lane_wr u_lane_wr (
        .rec_i  (asm_q),
        .cnt_i  (cnt_q),
        .byte_i (in_data),
        .rec_o  (asm_d)
    );

    // Assembly FSM plus output slot; in_ready and out_valid are plain flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            asm_q       <= '0;
            short_q     <= 1'b0;
            out_rec_q   <= '0;
            out_len_q   <= '0;
            out_short_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        asm_q <= asm_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_byte) begin
                            state_q    <= ST_HOLD;
                            in_ready_q <= 1'b0;
                            // in_last on the final lane is a normal full record
                            short_q    <= (cnt_q != CNT_LAST);
                        end
                    end
                end
                ST_HOLD: begin
                    if (load) begin
                        out_rec_q   <= asm_q;
                        out_len_q   <= cnt_q;
                        out_short_q <= short_q;
                        asm_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= ST_FILL;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase

            // A refill in the same cycle as a drain keeps the slot occupied.
            if (load) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_rec   = out_rec_q;
    assign out_len   = out_len_q;
    assign out_short = out_short_q;

endmodule
